// File: rtl/ysyx_22041412_lsu.sv
// ysyx_22041412_lsu -- load/store unit in the MEM stage, in front of the data cache.
//
// Takes one memory op at a time from EX and checks its width code and alignment.
// A legal op becomes a cache request that is held until the cache pulses dc_ready.
// The load data is then zero- or sign-extended and handed to WB.
// An illegal or misaligned op produces a one-cycle exception pulse and never reaches the cache.
// The unit also keeps load, store and stall counters, plus a sticky watchdog on cache response time.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   ex_valid / ex_ready       op handshake from EX (ex_ready high only in IDLE)
//   ex_is_store, ex_funct3    op kind and RV64 width/sign code
//   ex_addr, ex_wdata, ex_rd  effective address, store data (LSB-aligned), load destination
//   dc_valid .. dc_size       cache request, held stable while waiting
//   dc_rdata, dc_ready        cache load data (LSB-aligned) and one-cycle completion pulse
//   wb_valid / wb_ready       result handshake to WB; wb_we, wb_rd, wb_data carry the result
//   exc_valid, exc_cause,     one-cycle fault pulse
//   exc_addr                    cause: 0 load misalign, 1 store misalign, 2 illegal funct3
//   lsu_timeout               sticky watchdog flag
//   ld_cnt, st_cnt, stall_cnt performance counters (wrap modulo 2^CNT_W)

module ysyx_22041412_lsu #(
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic             ex_is_store,
  input  logic [2:0]       ex_funct3,
  input  logic [31:0]      ex_addr,
  input  logic [63:0]      ex_wdata,
  input  logic [4:0]       ex_rd,
  output logic             dc_valid,
  output logic             dc_rw_en,
  output logic [31:0]      dc_addr,
  output logic [63:0]      dc_wdata,
  output logic [2:0]       dc_size,
  input  logic [63:0]      dc_rdata,
  input  logic             dc_ready,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic             wb_we,
  output logic [4:0]       wb_rd,
  output logic [63:0]      wb_data,
  output logic             exc_valid,
  output logic [1:0]       exc_cause,
  output logic [31:0]      exc_addr,
  output logic             lsu_timeout,
  output logic [CNT_W-1:0] ld_cnt,
  output logic [CNT_W-1:0] st_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int DATA_W = 64;
  localparam int WD_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WB, S_FAULT} state_t;

  state_t state, state_nxt;

  // Op captured at accept; these drive the cache request for its whole lifetime.
  logic [31:0]       addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [4:0]        rd_p0;
  logic [2:0]        funct3_p0;
  logic              store_p0;

  logic [WD_W-1:0]   wd_cnt;
  logic              illegal;
  logic              misalign;

  function automatic logic [DATA_W-1:0] load_ext(input logic [2:0] f3,
                                                 input logic [DATA_W-1:0] raw);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    b = raw[7:0];
    h = raw[15:0];
    w = raw[31:0];
    case (f3)
      3'b000:  load_ext = DATA_W'(b);
      3'b001:  load_ext = DATA_W'(h);
      3'b010:  load_ext = DATA_W'(w);
      3'b100:  load_ext = {{(DATA_W-8){1'b0}},  raw[7:0]};
      3'b101:  load_ext = {{(DATA_W-16){1'b0}}, raw[15:0]};
      3'b110:  load_ext = {{(DATA_W-32){1'b0}}, raw[31:0]};
      default: load_ext = raw;
    endcase
  endfunction

  // Decode of the op presented by EX: an unsigned width (bit 2) only exists for loads narrower than 64 bits.
  always_comb begin
    illegal = ex_is_store ? ex_funct3[2] : (ex_funct3 == 3'b111);
    case (ex_funct3[1:0])
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = ex_addr[0];
      2'b10:   misalign = |ex_addr[1:0];
      default: misalign = |ex_addr[2:0];
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (ex_valid) state_nxt = (illegal || misalign) ? S_FAULT : S_REQ;
      S_REQ:   if (dc_ready) state_nxt = S_WB;
      S_WB:    if (wb_ready) state_nxt = S_IDLE;
      S_FAULT: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign ex_ready  = (state == S_IDLE);
  assign dc_valid  = (state == S_REQ);
  assign wb_valid  = (state == S_WB);
  assign exc_valid = (state == S_FAULT);
  assign dc_rw_en  = store_p0;
  assign dc_addr   = addr_p0;
  assign dc_wdata  = wdata_p0;
  // bytes-1 from the width code: 00->0, 01->1, 10->3, 11->7
  assign dc_size   = {funct3_p0[1] & funct3_p0[0], funct3_p0[1], funct3_p0[1] | funct3_p0[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      addr_p0     <= '0;
      wdata_p0    <= '0;
      rd_p0       <= '0;
      funct3_p0   <= '0;
      store_p0    <= 1'b0;
      wb_we       <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      exc_cause   <= '0;
      exc_addr    <= '0;
      wd_cnt      <= '0;
      lsu_timeout <= 1'b0;
      ld_cnt      <= '0;
      st_cnt      <= '0;
      stall_cnt   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        // accept stage: capture op, arm watchdog, record any fault
        S_IDLE: begin
          if (ex_valid) begin
            addr_p0   <= ex_addr;
            wdata_p0  <= ex_wdata;
            rd_p0     <= ex_rd;
            funct3_p0 <= ex_funct3;
            store_p0  <= ex_is_store;
            wd_cnt    <= '0;
            if (illegal || misalign) begin
              exc_cause <= illegal ? 2'd2 : (ex_is_store ? 2'd1 : 2'd0);
              exc_addr  <= ex_addr;
            end
          end
        end
        // request stage: wait for the cache, build the WB result on completion
        S_REQ: begin
          if (dc_ready) begin
            wb_we   <= ~store_p0;
            wb_rd   <= rd_p0;
            wb_data <= store_p0 ? '0 : load_ext(funct3_p0, dc_rdata);
            if (store_p0) st_cnt <= st_cnt + CNT_W'(1);
            else          ld_cnt <= ld_cnt + CNT_W'(1);
          end else begin
            stall_cnt <= stall_cnt + CNT_W'(1);
            wd_cnt    <= wd_cnt + WD_W'(1);
            // The flag is sticky, so a later watchdog wrap is harmless.
            if (wd_cnt + WD_W'(1) == WD_W'(TIMEOUT)) lsu_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041412_lsu.sv
`timescale 1ns/1ps
module tb_ysyx_22041412_lsu;

  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 64;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ex_valid, ex_ready, ex_is_store;
  logic [2:0]       ex_funct3;
  logic [31:0]      ex_addr;
  logic [63:0]      ex_wdata;
  logic [4:0]       ex_rd;
  logic             dc_valid, dc_rw_en, dc_ready;
  logic [31:0]      dc_addr;
  logic [63:0]      dc_wdata, dc_rdata;
  logic [2:0]       dc_size;
  logic             wb_valid, wb_ready, wb_we;
  logic [4:0]       wb_rd;
  logic [63:0]      wb_data;
  logic             exc_valid;
  logic [1:0]       exc_cause;
  logic [31:0]      exc_addr;
  logic             lsu_timeout;
  logic [CNT_W-1:0] ld_cnt, st_cnt, stall_cnt;

  always #5 clk = ~clk;

  ysyx_22041412_lsu #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_store(ex_is_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .dc_valid(dc_valid), .dc_rw_en(dc_rw_en), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_size(dc_size), .dc_rdata(dc_rdata), .dc_ready(dc_ready),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr),
    .lsu_timeout(lsu_timeout), .ld_cnt(ld_cnt), .st_cnt(st_cnt), .stall_cnt(stall_cnt)
  );

  typedef struct {
    bit          is_exc;
    bit          we;
    logic [4:0]  rd;
    logic [63:0] data;
    logic [1:0]  cause;
    logic [31:0] addr;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    bit          rw;
    logic [2:0]  size;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          lat;
  } req_t;

  exp_t            exp_q[$];
  req_t            req_q[$];
  int              n_vec = 0;
  int              n_err = 0;
  longint unsigned exp_ld = 0, exp_st = 0, exp_stall = 0;
  bit              wb_hold = 1'b0;
  bit              chk_to = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: keep the low 8*n bits, then fill the rest with the top kept bit for signed widths.
  function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] raw);
    int nbytes;
    logic [63:0] mask, v;
    nbytes = 1 << f3[1:0];
    if (nbytes == 8) return raw;
    mask = (64'd1 << (8 * nbytes)) - 64'd1;
    v = raw & mask;
    if (!f3[2] && v[8*nbytes-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic plan(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [63:0] wdata, input logic [4:0] rd,
                      input logic [63:0] rdata, input int lat);
    exp_t e;
    req_t r;
    int   nbytes;
    nbytes = 1 << f3[1:0];
    e = '{default: 0};
    if ((!st && f3 == 3'b111) || (st && f3[2])) begin
      e.is_exc = 1; e.cause = 2'd2; e.addr = addr;
    end else if ((addr % nbytes) != 0) begin
      e.is_exc = 1; e.cause = st ? 2'd1 : 2'd0; e.addr = addr;
    end else begin
      r.addr = addr; r.rw = st; r.size = 3'(nbytes - 1);
      r.wdata = wdata; r.rdata = rdata; r.lat = lat;
      req_q.push_back(r);
      e.we = !st; e.rd = rd; e.data = st ? 64'd0 : ref_load(f3, rdata);
      if (st) exp_st++; else exp_ld++;
      exp_stall += longint'(lat);
    end
    exp_q.push_back(e);
  endtask

  task automatic send(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [63:0] wdata, input logic [4:0] rd);
    int n = 0;
    while (!ex_ready && n < 200) begin @(posedge clk); #1; n++; end
    check("accept_ex_ready", ex_ready, 1);
    ex_valid = 1'b1; ex_is_store = st; ex_funct3 = f3;
    ex_addr = addr; ex_wdata = wdata; ex_rd = rd;
    @(posedge clk); #1;
    ex_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!ex_ready && n < 200) begin @(posedge clk); #1; n++; end
    check("return_to_idle", ex_ready, 1);
  endtask

  task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [63:0] wdata, input logic [4:0] rd,
                       input logic [63:0] rdata, input int lat);
    plan(st, f3, addr, wdata, rd, rdata, lat);
    send(st, f3, addr, wdata, rd);
    wait_idle();
  endtask

  // WB consumer: random backpressure unless a test holds it off.
  initial begin
    wb_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      wb_ready = wb_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Cache model: checks each held request, answers after the planned number of stall cycles,
  // and throws stray dc_ready pulses and garbage read data when idle.
  bit   c_busy = 1'b0, c_bogus = 1'b0;
  int   c_lat = 0, c_rcyc = 0;
  req_t c_cur;
  initial begin
    dc_ready = 1'b0;
    dc_rdata = '0;
    forever begin
      @(posedge clk); #1;
      dc_ready = 1'b0;
      dc_rdata = {$urandom, $urandom};
      if (rst) begin
        c_busy = 1'b0;
      end else if (dc_valid) begin
        if (!c_busy) begin
          c_busy = 1'b1; c_rcyc = 0; c_bogus = 1'b0;
          if (req_q.size() == 0) begin
            n_vec++; n_err++; c_bogus = 1'b1; c_lat = 0;
            $display("FAIL dc_unexpected: got dc_valid=1 addr 0x%0h, expected no request", dc_addr);
          end else begin
            c_cur = req_q.pop_front();
            c_lat = c_cur.lat;
          end
        end
        if (!c_bogus) begin
          check("dc_addr", dc_addr, c_cur.addr);
          check("dc_rw_en", dc_rw_en, c_cur.rw);
          check("dc_size", dc_size, c_cur.size);
          if (c_cur.rw) check("dc_wdata", dc_wdata, c_cur.wdata);
        end
        if (chk_to) check("lsu_timeout_rise", lsu_timeout, c_rcyc >= TIMEOUT);
        c_rcyc++;
        if (c_lat == 0) begin
          dc_ready = 1'b1;
          if (!c_bogus) dc_rdata = c_cur.rdata;
          c_busy = 1'b0;
        end else begin
          c_lat--;
        end
      end else begin
        dc_ready = ($urandom_range(0, 7) == 0);
      end
    end
  end

  // Monitor: pops the scoreboard whenever a result or fault is presented.
  bit          m_hold = 1'b0, m_pexc = 1'b0;
  logic [63:0] m_pdata;
  logic        m_pwe;
  exp_t        m_e;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_hold = 1'b0; m_pexc = 1'b0;
      end else begin
        if (m_hold) begin
          check("wb_hold_valid", wb_valid, 1);
          check("wb_hold_data", wb_data, m_pdata);
          check("wb_hold_we", wb_we, m_pwe);
        end
        if (m_pexc) check("ex_ready_after_exc", ex_ready, 1);
        if (wb_valid) check("ex_ready_in_wb", ex_ready, 0);
        if (exc_valid) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL exc_unexpected: got cause %0d addr 0x%0h, expected nothing", exc_cause, exc_addr);
          end else begin
            m_e = exp_q.pop_front();
            check("exc_kind", exc_valid, m_e.is_exc);
            if (m_e.is_exc) begin
              check("exc_cause", exc_cause, m_e.cause);
              check("exc_addr", exc_addr, m_e.addr);
            end
          end
        end
        if (wb_valid && wb_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL wb_unexpected: got data 0x%0h, expected nothing", wb_data);
          end else begin
            m_e = exp_q.pop_front();
            check("wb_kind", wb_valid, !m_e.is_exc);
            if (!m_e.is_exc) begin
              check("wb_we", wb_we, m_e.we);
              if (m_e.we) check("wb_rd", wb_rd, m_e.rd);
              check("wb_data", wb_data, m_e.data);
            end
          end
        end
        m_hold  = wb_valid && !wb_ready;
        m_pdata = wb_data;
        m_pwe   = wb_we;
        m_pexc  = exc_valid;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    int          n;
    bit          st;
    logic [2:0]  f3;
    logic [31:0] addr;
    req_t        r;
    ex_valid = 1'b0; ex_is_store = 1'b0; ex_funct3 = '0;
    ex_addr = '0; ex_wdata = '0; ex_rd = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ex_ready", ex_ready, 1);
    check("rst_dc_valid", dc_valid, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_exc_valid", exc_valid, 0);
    check("rst_dc_addr", dc_addr, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_ld_cnt", ld_cnt, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_timeout", lsu_timeout, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // lb / lbu of 0x80
    do_op(1'b0, 3'b000, 32'h8000_0003, 64'h0, 5'd1, 64'hABCD_0000_0000_0080, 2);
    do_op(1'b0, 3'b100, 32'h8000_0003, 64'h0, 5'd2, 64'hABCD_0000_0000_0080, 1);
    // sd with four stall cycles
    do_op(1'b1, 3'b011, 32'h8000_0010, 64'h1122_3344_5566_7788, 5'd0, 64'h0, 4);
    check("sd_st_cnt", st_cnt, exp_st);
    check("sd_stall_cnt", stall_cnt, exp_stall);
    // faults
    do_op(1'b0, 3'b010, 32'h8000_0002, 64'h0, 5'd3, 64'h0, 0);
    check("fault_ld_cnt", ld_cnt, exp_ld);
    do_op(1'b0, 3'b111, 32'h8000_0000, 64'h0, 5'd4, 64'h0, 0);
    do_op(1'b1, 3'b001, 32'h8000_0001, 64'h55, 5'd5, 64'h0, 0);
    // lwu with WB backpressure
    plan(1'b0, 3'b110, 32'h8000_0004, 64'h0, 5'd7, 64'h0000_0000_FFFF_FFFF, 1);
    wb_hold = 1'b1;
    send(1'b0, 3'b110, 32'h8000_0004, 64'h0, 5'd7);
    n = 0;
    while (!wb_valid && n < 50) begin @(posedge clk); #1; n++; end
    check("lwu_wb_valid", wb_valid, 1);
    repeat (3) @(posedge clk);
    #1;
    check("lwu_held_data", wb_data, 64'h0000_0000_FFFF_FFFF);
    wb_hold = 1'b0;
    wait_idle();

    // randomized ops, latencies below the watchdog limit
    for (int i = 0; i < 150; i++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      addr = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'h7;
      do_op(st, f3, addr, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
            {$urandom, $urandom}, $urandom_range(0, 6));
    end
    check("no_early_timeout", lsu_timeout, 0);

    // watchdog: ten stall cycles against a limit of eight
    chk_to = 1'b1;
    do_op(1'b0, 3'b011, 32'h8000_0100, 64'h0, 5'd9, 64'hDEAD_BEEF_0BAD_F00D, 10);
    chk_to = 1'b0;
    check("timeout_sticky", lsu_timeout, 1);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    check("scoreboard_drained", exp_q.size(), 0);
    check("final_ld_cnt", ld_cnt, exp_ld);
    check("final_st_cnt", st_cnt, exp_st);
    check("final_stall_cnt", stall_cnt, exp_stall);

    // reset in the middle of a request
    r = '{addr: 32'h8000_0200, rw: 1'b0, size: 3'd7, wdata: 64'h0, rdata: 64'h0, lat: 30};
    req_q.push_back(r);
    send(1'b0, 3'b011, 32'h8000_0200, 64'h0, 5'd3);
    check("mid_req_dc_valid", dc_valid, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_dc_valid", dc_valid, 0);
    check("mid_rst_ex_ready", ex_ready, 1);
    check("mid_rst_ld_cnt", ld_cnt, 0);
    check("mid_rst_st_cnt", st_cnt, 0);
    check("mid_rst_stall_cnt", stall_cnt, 0);
    check("mid_rst_timeout", lsu_timeout, 0);
    check("mid_rst_wb_valid", wb_valid, 0);
    rst = 1'b0;
    req_q.delete();
    exp_q.delete();
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
